acc_req_issuer: RTL
===================

# acc_req_issuer

Initiator side of the FPR accumulator request channel. Buffers accumulate operations (target accumulator index + 32-bit addend) from the issue stage in one small FIFO per accumulator. Presents each FIFO head to the floating-point register file as a valid/ready request, which that block folds into its accumulator register through its fadd pipeline. Also reports when all queues are drained, so reads of accumulator registers can be held until every queued addend has been handed over.

## Interface
- N_ACC, 3, number of accumulator channels (FPR slots 2**REG_WIDTH-N_ACC .. 2**REG_WIDTH-1)
- DEPTH, 4, entries per accumulator FIFO; power of two, >= 2
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  issue stage offers an accumulate op
- in_ready  output  1  op accepted when in_valid && in_ready at posedge
- in_acc  input  $clog2(N_ACC)  target accumulator index
- in_data  input  32  addend (IEEE single)
- req_valid  output  N_ACC  per-channel request valid (drives acc_req[i].valid)
- req_ready  input  N_ACC  per-channel ready from register file (acc_req[i].ready)
- req_data  output  32 x N_ACC  per-channel addend (drives acc_data[i])
- drained  output  1  all FIFOs empty
- occupancy  output  ($clog2(DEPTH)+1) x N_ACC  per-channel entry count

## Operation
- Per channel i: circular buffer of DEPTH x 32, read pointer, write pointer, count (0..DEPTH). Pointers wrap modulo DEPTH.
- Push: in_valid && in_ready && in_acc==i -> write in_data at wptr[i], wptr[i]++, count[i]++.
- Pop: req_valid[i] && req_ready[i] -> rptr[i]++, count[i]--.
- Simultaneous push and pop on the same channel: both happen, count unchanged, FIFO order preserved.
- Push to channel i and pop on channel j != i in the same cycle: independent.
- req_valid[i] = count[i] != 0; req_data[i] = buf[i][rptr[i]]. Held stable while req_valid && !req_ready.
- in_ready = count[in_acc] < DEPTH. Depends only on registered count. Frees no slot for a same-cycle pop; a full queue refuses the push even if it pops that cycle.
- in_acc >= N_ACC: in_ready=1, op discarded, no state change.
- drained = all count[i]==0. occupancy[i] = count[i].
- Order is guaranteed only within a channel. Channels issue concurrently.

## Timing
- Reset: all counts, rptr, wptr = 0. Outputs after reset: req_valid=0, drained=1, occupancy=0, in_ready=1. req_data undefined (don't care while !req_valid). Buffer contents are not cleared.
- Reset mid-operation drops all queued ops. The register-file side is reset in the same cycle, so no request is left dangling.
- Latency without bypass: op accepted at edge k -> req_valid[i]=1 from cycle k+1. Handed over at the first edge where req_ready[i]=1.
- Throughput: one push per cycle total, one pop per cycle per channel. The register file raises ready about once per fadd latency per channel, so queues absorb bursts.
- req_ready is registered logic on the receiver side, so no combinational loop exists.

## Configuration
- ACC_REQ_BYPASS_EN defined:
  - Condition: count[i]==0, in_valid, in_acc==i, req_ready[i]=1.
  - Then req_valid[i]=1 and req_data[i]=in_data combinationally in that same cycle.
  - The op is consumed without writing the buffer: pointers and count unchanged.
  - Zero-cycle latency for that op.
  - If req_ready[i]=0 the op is enqueued normally.
  - drained is computed from counts only, so it stays 1 during a bypass.
- ACC_REQ_BYPASS_EN undefined: no combinational in->req path; minimum latency 1 cycle as above.

## Test plan
- Reset, then idle: req_valid=000, drained=1, in_ready=1, occupancy all 0.
- Push 1.0, 2.0, 3.0 to acc 1 with req_ready[1]=0, then hold ready=1 -> req_data[1] = 0x3F800000, 0x40000000, 0x40400000 on three consecutive edges; drained rises the cycle after the last pop.
- Push 5 ops to acc 0 with ready=0 (DEPTH=4) -> in_ready=0 on the 5th, occupancy[0]=4; one pop frees a slot and the 5th is accepted next cycle. Repeat until wptr has wrapped twice and check order is preserved.
- Channel 2 full and popping while a push to channel 2 is offered -> push refused, count drops to 3. Channel 1 non-empty, push and pop on it in the same cycle -> count unchanged, order intact.
- in_acc=3 with in_valid -> accepted, no queue changes. Reset asserted with 2 entries queued -> next cycle req_valid=000, drained=1.
- With ACC_REQ_BYPASS_EN, empty acc 0 with ready=1, push 0x41200000 -> req_valid[0]=1, req_data[0]=0x41200000 the same cycle, occupancy[0] stays 0. Without the macro, req_valid[0] rises one cycle later.

Source files
------------

// File: rtl/acc_req_issuer.sv
// acc_req_issuer: initiator side of the FPR accumulator request channel.
// Keeps one circular FIFO per accumulator and presents each FIFO head as a
// valid/ready request toward the register file. A push and a pop on the same
// channel in the same cycle leave the count unchanged and keep FIFO order.
// Optional build macro: ACC_REQ_BYPASS_EN adds a zero-latency path from the
// issue stage straight to req_data when the target queue is empty and the
// register file is ready. In that case the buffer is not written.
module acc_req_issuer #(
  parameter int unsigned N_ACC = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [$clog2(N_ACC)-1:0]                   in_acc,
  input  logic [31:0]                                in_data,
  output logic [N_ACC-1:0]                           req_valid,
  input  logic [N_ACC-1:0]                           req_ready,
  output logic [N_ACC-1:0][31:0]                     req_data,
  output logic                                       drained,
  output logic [N_ACC-1:0][$clog2(DEPTH):0]          occupancy
);

  localparam int unsigned AW = $clog2(N_ACC);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   mem_q   [N_ACC][DEPTH];
  logic [PW-1:0] rptr_q  [N_ACC];
  logic [PW-1:0] wptr_q  [N_ACC];
  logic [CW-1:0] count_q [N_ACC];

  logic [N_ACC-1:0] sel;
  logic [N_ACC-1:0] push;
  logic [N_ACC-1:0] pop;
  logic [N_ACC-1:0] bypass;

  // Decode the target channel, then derive ready, push, pop and bypass per channel.
  always_comb begin
    in_ready = 1'b1;
    sel      = '0;
    push     = '0;
    pop      = '0;
    bypass   = '0;
    for (int unsigned i = 0; i < N_ACC; i++) begin
      sel[i] = (in_acc == AW'(i));
      if (sel[i]) begin
        in_ready = (count_q[i] != CW'(DEPTH));
      end
`ifdef ACC_REQ_BYPASS_EN
      bypass[i] = (count_q[i] == '0) && in_valid && sel[i] && req_ready[i];
`endif
      push[i] = in_valid && sel[i] && (count_q[i] != CW'(DEPTH)) && !bypass[i];
      pop[i]  = (count_q[i] != '0) && req_ready[i];
    end
  end

  // Present queue heads, or the incoming op while it bypasses an empty queue.
  always_comb begin
    drained   = 1'b1;
    req_valid = '0;
    req_data  = '0;
    occupancy = '0;
    for (int unsigned i = 0; i < N_ACC; i++) begin
      req_valid[i] = (count_q[i] != '0) || bypass[i];
      req_data[i]  = bypass[i] ? in_data : mem_q[i][rptr_q[i]];
      occupancy[i] = count_q[i];
      if (count_q[i] != '0) begin
        drained = 1'b0;
      end
    end
  end

  // Write accepted addends into the buffers. Contents survive reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_ACC; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= in_data;
      end
    end
  end

  // Advance pointers and counts. Reset empties every queue.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_ACC; i++) begin
      if (reset) begin
        rptr_q[i]  <= '0;
        wptr_q[i]  <= '0;
        count_q[i] <= '0;
      end else begin
        if (push[i]) begin
          wptr_q[i] <= wptr_q[i] + PW'(1);
        end
        if (pop[i]) begin
          rptr_q[i] <= rptr_q[i] + PW'(1);
        end
        count_q[i] <= count_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

endmodule
